// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the program counter, issues one-word reads to a one-cycle-latency
// instruction BRAM, and buffers returned words with their PCs in a 2-entry
// queue presented over a valid/ready handshake. Redirects flush everything
// and restart fetch at the target.
// Optional feature macro: FETCH_HALT_EN (stop fetching after enqueuing an
// all-zero instruction word until redirect or reset).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        inst,
  output logic [31:0]        pc,
  output logic               halted
);

  // Instruction and machine-word widths used for the queue storage.
  localparam int LEN_INST = 32;
  localparam int LEN_WORD = 32;

  // Program counter of the next word to request.
  logic [LEN_WORD-1:0] fetch_pc_q, fetch_pc_d;

  // One outstanding BRAM read and the PC it was issued for.
  logic                inflight_q, inflight_d;
  logic [LEN_WORD-1:0] inflight_pc_q, inflight_pc_d;

  // Two-entry circular queue of {instruction, pc}.
  logic [LEN_INST-1:0] inst_q [2];
  logic [LEN_INST-1:0] inst_d [2];
  logic [LEN_WORD-1:0] pc_q [2];
  logic [LEN_WORD-1:0] pc_d [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q, count_d;

  // Halt flag; stays constant zero unless the halt feature is built in.
  logic                halted_q, halted_d;

  // Handshake and flow-control helpers.
  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occupancy;

  // Queue head drives decode directly; a pop happens whenever decode takes it.
  always_comb begin
    out_valid = (count_q != 2'd0);
    inst      = inst_q[rd_ptr_q];
    pc        = pc_q[rd_ptr_q];
    halted    = halted_q;
    pop       = out_valid & out_ready;
    push      = inflight_q & ~redirect;
  end

  // Issue a read only if the queue can absorb it next cycle: the entries
  // still held after this cycle's pop plus the read already in flight must
  // leave a free slot. This is what keeps the queue from ever overflowing.
  always_comb begin
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = ~redirect & ~halted_q & (occupancy < 3'd2);
    imem_en   = issue & rstn;
    imem_addr = fetch_pc_q[IMEM_AW+1:2];
  end

  // Next-state logic: redirect flushes and retargets; otherwise push the
  // returning word, pop on acceptance and advance the PC on issue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    inst_d        = inst_q;
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    halted_d      = halted_q;

    if (redirect) begin
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      inflight_d = 1'b0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      halted_d   = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
        inst_d[wr_ptr_q] = imem_rdata;
        pc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d         = ~wr_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end else begin
        inflight_d = 1'b0;
      end
`ifdef FETCH_HALT_EN
      if (push && (imem_rdata == '0)) begin
        halted_d = 1'b1;
      end
`else
      halted_d = 1'b0;
`endif
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      halted_q      <= halted_d;
    end
  end

  // Queue payload needs no reset: it is only observed when count is nonzero.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A directed table covers startup and backpressure, hand sequences cover
// redirects, wrap-around, mid-run reset and (with FETCH_HALT_EN) halting,
// and a randomized phase compares against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          IMEM_AW  = 14;

  logic               clk = 1'b0;
  logic               rstn;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        inst;
  logic [31:0]        pc;
  logic               halted;

  int vectors     = 0;
  int miscompares = 0;
  bit halt_mem    = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inst       (inst),
    .pc         (pc),
    .halted     (halted)
  );

  // Memory contents: word k holds k+1, except word 2 is zero in halt mode.
  function automatic logic [31:0] mem_at(input logic [IMEM_AW-1:0] idx);
    if (halt_mem && (idx == 2)) return 32'h0;
    return 32'(idx) + 32'd1;
  endfunction

  // One-cycle-latency BRAM behaviour.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_at(imem_addr);
  end

  // Reference model: a plain queue of fetched {inst, pc} plus the pending read.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t             mq[$];
  logic               m_inflight;
  logic [31:0]        m_inflight_pc;
  logic [31:0]        m_fetch_pc;
  logic               m_halted;
  logic               m_pop;
  logic               exp_valid;
  logic               exp_en;
  logic [31:0]        exp_pc;
  logic [31:0]        exp_inst;
  logic [IMEM_AW-1:0] exp_addr;

  task automatic model_reset();
    mq.delete();
    m_inflight    = 1'b0;
    m_inflight_pc = 32'h0;
    m_fetch_pc    = RESET_PC;
    m_halted      = 1'b0;
  endtask

  task automatic model_comb();
    int occ;
    exp_valid = (mq.size() != 0);
    exp_pc    = exp_valid ? mq[0].pc : 32'h0;
    exp_inst  = exp_valid ? mq[0].inst : 32'h0;
    m_pop     = exp_valid && out_ready;
    occ       = mq.size() + int'(m_inflight) - int'(m_pop);
    exp_en    = !redirect && !m_halted && (occ < 2);
    exp_addr  = m_fetch_pc[IMEM_AW+1:2];
  endtask

  task automatic model_step();
    entry_t e;
    if (redirect) begin
      mq.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      m_halted   = 1'b0;
      m_inflight = 1'b0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_inflight) begin
        e.inst = mem_at(m_inflight_pc[IMEM_AW+1:2]);
        e.pc   = m_inflight_pc;
        mq.push_back(e);
`ifdef FETCH_HALT_EN
        if (e.inst == 32'h0) m_halted = 1'b1;
`endif
      end
      if (exp_en) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = m_fetch_pc + 32'd4;
        m_inflight    = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and predict outputs.
  task automatic applyStimulus(input logic r, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect    = r;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
    model_comb();
  endtask

  // Compare every visible output with the model prediction.
  task automatic checkOutput(input string name);
    check_val({name, ".out_valid"}, {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check_val({name, ".pc"}, pc, exp_pc);
      check_val({name, ".inst"}, inst, exp_inst);
    end
    check_val({name, ".imem_en"}, {31'b0, imem_en}, {31'b0, exp_en});
    if (exp_en) check_val({name, ".imem_addr"}, 32'(imem_addr), 32'(exp_addr));
    check_val({name, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
  endtask

  task automatic model_cycle(input string name, input logic r, input logic [31:0] rpc, input logic rdy);
    applyStimulus(r, rpc, rdy);
    checkOutput(name);
    finish_cycle();
  endtask

  // Fill the queue, redirect, then check the restart timing and first words.
  task automatic redirect_seq(input string name, input logic [31:0] target,
                              input logic [IMEM_AW-1:0] first_addr,
                              input logic [31:0] pc0, input logic [31:0] inst0,
                              input logic [31:0] pc1, input logic [31:0] inst1);
    for (int i = 0; i < 3; i++) model_cycle({name, ".fill"}, 1'b0, 32'h0, 1'b0);
    model_cycle({name, ".redir"}, 1'b1, target, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput({name, ".n1"});
    check_val({name, ".n1.valid"}, {31'b0, out_valid}, 32'd0);
    check_val({name, ".n1.en"}, {31'b0, imem_en}, 32'd1);
    check_val({name, ".n1.addr"}, 32'(imem_addr), 32'(first_addr));
    finish_cycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput({name, ".n2"});
    check_val({name, ".n2.valid"}, {31'b0, out_valid}, 32'd0);
    finish_cycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput({name, ".n3"});
    check_val({name, ".n3.valid"}, {31'b0, out_valid}, 32'd1);
    check_val({name, ".n3.pc"}, pc, pc0);
    check_val({name, ".n3.inst"}, inst, inst0);
    finish_cycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput({name, ".n4"});
    check_val({name, ".n4.pc"}, pc, pc1);
    check_val({name, ".n4.inst"}, inst, inst1);
    finish_cycle();
  endtask

  typedef struct {
    logic               ready;
    logic               exp_valid;
    logic [31:0]        exp_pc;
    logic [31:0]        exp_inst;
    logic               exp_en;
    logic [IMEM_AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [11];

  // Hang guard.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Startup with a 5-cycle stall right after the first valid word.
    vecs[0]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 14'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 14'd1};
    vecs[2]  = '{1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 14'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 14'd0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 14'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 14'd0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 14'd0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0, 32'h1, 1'b1, 14'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'h4, 32'h2, 1'b1, 14'd3};
    vecs[9]  = '{1'b1, 1'b1, 32'h8, 32'h3, 1'b1, 14'd4};
    vecs[10] = '{1'b1, 1'b1, 32'hC, 32'h4, 1'b1, 14'd5};

    rstn        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    imem_rdata  = 32'h0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("reset.out_valid", {31'b0, out_valid}, 32'd0);
    check_val("reset.imem_en", {31'b0, imem_en}, 32'd0);
    check_val("reset.halted", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    model_reset();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 32'h0, vecs[i].ready);
      check_val($sformatf("table%0d.out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check_val($sformatf("table%0d.pc", i), pc, vecs[i].exp_pc);
        check_val($sformatf("table%0d.inst", i), inst, vecs[i].exp_inst);
      end
      check_val($sformatf("table%0d.imem_en", i), {31'b0, imem_en}, {31'b0, vecs[i].exp_en});
      if (vecs[i].exp_en)
        check_val($sformatf("table%0d.imem_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
      finish_cycle();
    end

    redirect_seq("redir100", 32'h0000_0100, 14'd64, 32'h100, 32'd65, 32'h104, 32'd66);
    redirect_seq("redir103", 32'h0000_0103, 14'd64, 32'h100, 32'd65, 32'h104, 32'd66);
    redirect_seq("wrap", 32'hFFFF_FFFC, 14'h3FFF, 32'hFFFF_FFFC, 32'h4000, 32'h0, 32'h1);

    // Back-to-back redirects: the second target wins.
    model_cycle("dbl.r1", 1'b1, 32'h200, 1'b1);
    model_cycle("dbl.r2", 1'b1, 32'h300, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("dbl.n1");
    check_val("dbl.n1.addr", 32'(imem_addr), 32'h0C0);
    finish_cycle();
    model_cycle("dbl.n2", 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("dbl.n3");
    check_val("dbl.n3.pc", pc, 32'h300);
    finish_cycle();

`ifdef FETCH_HALT_EN
    halt_mem = 1'b1;
    model_cycle("halt.redir", 1'b1, 32'h0, 1'b1);
    for (int i = 1; i <= 4; i++) model_cycle($sformatf("halt.n%0d", i), 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("halt.n5");
    check_val("halt.n5.halted", {31'b0, halted}, 32'd1);
    check_val("halt.n5.pc", pc, 32'h8);
    check_val("halt.n5.inst", inst, 32'h0);
    check_val("halt.n5.en", {31'b0, imem_en}, 32'd0);
    finish_cycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("halt.n6");
    check_val("halt.n6.pc", pc, 32'hC);
    check_val("halt.n6.en", {31'b0, imem_en}, 32'd0);
    finish_cycle();
    for (int i = 7; i <= 9; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("halt.n%0d", i));
      check_val($sformatf("halt.n%0d.valid", i), {31'b0, out_valid}, 32'd0);
      check_val($sformatf("halt.n%0d.halted", i), {31'b0, halted}, 32'd1);
      check_val($sformatf("halt.n%0d.en", i), {31'b0, imem_en}, 32'd0);
      finish_cycle();
    end
    halt_mem = 1'b0;
    model_cycle("unhalt.redir", 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("unhalt.n1");
    check_val("unhalt.n1.halted", {31'b0, halted}, 32'd0);
    check_val("unhalt.n1.en", {31'b0, imem_en}, 32'd1);
    check_val("unhalt.n1.addr", 32'(imem_addr), 32'd0);
    finish_cycle();
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [31:0] rpc;
      logic        rdy;
      r   = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      model_cycle($sformatf("rand%0d", i), r, rpc, rdy);
    end

    // Reset in the middle of traffic.
    model_cycle("prereset", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    rstn = 1'b0;
    #1;
    check_val("midreset.out_valid", {31'b0, out_valid}, 32'd0);
    check_val("midreset.imem_en", {31'b0, imem_en}, 32'd0);
    check_val("midreset.halted", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    model_reset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("postreset.c0");
    check_val("postreset.c0.addr", 32'(imem_addr), 32'(RESET_PC[IMEM_AW+1:2]));
    finish_cycle();
    model_cycle("postreset.c1", 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("postreset.c2");
    check_val("postreset.c2.pc", pc, RESET_PC);
    check_val("postreset.c2.inst", inst, 32'h1);
    finish_cycle();
    for (int i = 3; i < 8; i++) model_cycle($sformatf("postreset.c%0d", i), 1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
